// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor.
//   S_IDLE/S_RUN/S_DONE : FSM state encodings
//   DEF_WIDTH           : default operand width
package serial_sub_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/serial_sub_if.sv
// Start/done handshake bundle for serial_sub.
//   master : drives start, a, b; observes busy, done, diff, borrow
//   slave  : the subtractor side
interface serial_sub_if #(parameter int WIDTH = serial_sub_pkg::DEF_WIDTH);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/serial_sub_full_sub.sv
// 1-bit full subtractor cell: d = x - y - bin, with borrow out.
//   x, y, bin : minuend bit, subtrahend bit, borrow in
//   d, bout   : difference bit, borrow out
module full_sub (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic xy_x;

  assign xy_x = x ^ y;
  assign d    = xy_x ^ bin;
  // Borrow when y beats x outright, or when they tie and a borrow is pending.
  assign bout = (~x & y) | (~xy_x & bin);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : start/a/b in; busy/done/diff/borrow out (all registered)
// Latency from accept to done is WIDTH cycles; busy covers RUN and DONE.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_sub_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [WIDTH-1:0] res_q, res_d, diff_q, diff_d;
  logic             bw_q, bw_d, borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             d_bit, bw_next;

  full_sub u_fs (
    .x    (ra_q[0]),
    .y    (rb_q[0]),
    .bin  (bw_q),
    .d    (d_bit),
    .bout (bw_next)
  );

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    bw_d     = bw_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_RUN;
          ra_d     = bus.a;
          rb_d     = bus.b;
          bw_d     = 1'b0;
          cnt_d    = '0;
          res_d    = '0;
          diff_d   = '0;
          borrow_d = 1'b0;
        end
      end
      S_RUN: begin
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        bw_d  = bw_next;
        // New bit enters at the MSB; after WIDTH shifts bit 0 sits in the LSB.
        res_d = {d_bit, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = S_DONE;
          diff_d   = {d_bit, res_q[WIDTH-1:1]};
          borrow_d = bw_next;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bw_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      bw_q     <= bw_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.busy   = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(8)) bus8 ();
  serial_sub_if #(.WIDTH(4)) bus4 ();

  serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_sub #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called just after an accept edge; watches cycles until busy falls.
  task automatic collect8(output int lat, output int busy_n, output int done_n,
                          output logic [7:0] d, output logic bo);
    lat = -1; busy_n = 0; done_n = 0; d = '0; bo = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus8.busy) busy_n++;
      if (bus8.done) begin
        done_n++;
        lat = k;
        d   = bus8.diff;
        bo  = bus8.borrow;
      end
      if (!bus8.busy) break;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b);
    int lat, bn, dn;
    logic [7:0] d;
    logic bo;
    logic [8:0] ref_full;
    bus8.start = 1'b1; bus8.a = a; bus8.b = b;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom);
    collect8(lat, bn, dn, d, bo);
    ref_full = {1'b0, a} - {1'b0, b};
    check({tag, ".done_cnt"}, 32'(dn), 32'd1);
    check({tag, ".latency"},  32'(lat), 32'd8);
    check({tag, ".busy_cyc"}, 32'(bn), 32'd9);
    check({tag, ".diff"},     32'(d), 32'(ref_full[7:0]));
    check({tag, ".borrow"},   32'(bo), 32'(a < b));
  endtask

  initial begin
    int lat, bn, dn;
    logic [7:0] d;
    logic bo;
    logic [3:0] d4;
    logic b4;
    int fail4;

    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.busy",   32'(bus8.busy),   32'd0);
    check("rst.done",   32'(bus8.done),   32'd0);
    check("rst.diff",   32'(bus8.diff),   32'd0);
    check("rst.borrow", 32'(bus8.borrow), 32'd0);
    rst_n = 1'b1;

    op8("t1", 8'h5A, 8'h3C);
    op8("t2", 8'h00, 8'h01);
    op8("t3", 8'hFF, 8'hFF);

    // start held high through RUN while operands change
    bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h01;
    @(posedge clk); #1;
    bus8.a = 8'hAA; bus8.b = 8'h55;
    collect8(lat, bn, dn, d, bo);
    check("hold.done_cnt", 32'(dn), 32'd1);
    check("hold.diff",     32'(d),  32'h0F);
    check("hold.borrow",   32'(bo), 32'd0);
    check("hold.idle",     32'(bus8.busy), 32'd0);
    @(posedge clk); #1;
    bus8.start = 1'b0;
    collect8(lat, bn, dn, d, bo);
    check("hold2.latency", 32'(lat), 32'd8);
    check("hold2.diff",    32'(d),   32'h55);

    // reset mid-operation, during the 4th RUN cycle
    bus8.start = 1'b1; bus8.a = 8'hC3; bus8.b = 8'h21;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst.busy",   32'(bus8.busy),   32'd0);
    check("mrst.done",   32'(bus8.done),   32'd0);
    check("mrst.diff",   32'(bus8.diff),   32'd0);
    check("mrst.borrow", 32'(bus8.borrow), 32'd0);
    dn = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus8.done) dn++;
    end
    check("mrst.no_done", 32'(dn), 32'd0);

    // random operands against plain arithmetic
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op8("rnd", 8'($urandom), 8'($urandom));
    end

    // exhaustive WIDTH=4 sweep
    fail4 = 0;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        bus4.start = 1'b1; bus4.a = 4'(ia); bus4.b = 4'(ib);
        @(posedge clk); #1;
        bus4.start = 1'b0; bus4.a = 4'($urandom); bus4.b = 4'($urandom);
        bn = 0; dn = 0; d4 = '0; b4 = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (bus4.busy) bn++;
          if (bus4.done) begin dn++; d4 = bus4.diff; b4 = bus4.borrow; end
          if (!bus4.busy) break;
        end
        check("w4.diff",     32'(d4), 32'((ia - ib) & 15));
        check("w4.borrow",   32'(b4), 32'(ia < ib));
        check("w4.busy_cyc", 32'(bn), 32'd5);
        check("w4.done_cnt", 32'(dn), 32'd1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
